// File: rtl/wavetable_scheduler.sv
// Shares one async-read sine ROM across NUM_VOICES phase accumulators, one mix per sample_tick.
// Optional GAIN_WEIGHT_EN: weights each voice by its 4-bit gain and widens mix_out by 4 bits.
module wavetable_scheduler #(
  parameter int NUM_VOICES = 4,
`ifdef GAIN_WEIGHT_EN
  localparam int MIX_W = 16 + $clog2(NUM_VOICES) + 4
`else
  localparam int MIX_W = 16 + $clog2(NUM_VOICES)
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_sample_tick,
  input  logic [16*NUM_VOICES-1:0] i_phase_inc,
  input  logic [NUM_VOICES-1:0]   i_voice_en,
  input  logic [4*NUM_VOICES-1:0] i_voice_gain,
  output logic [7:0]              o_lut_addr,
  input  logic [15:0]             i_lut_data,
  output logic [MIX_W-1:0]        o_mix_out,
  output logic                    o_mix_valid,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

`ifdef GAIN_WEIGHT_EN
  localparam int TERM_W = 20;
`else
  localparam int TERM_W = 16;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [VIDX_W-1:0]   r_voiceIdx;
  logic [MIX_W-1:0]    r_acc;
  logic [15:0]         r_phase [NUM_VOICES];

  logic [15:0]         w_curInc;
  logic                w_curEn;
  logic [TERM_W-1:0]   w_term;
  logic                w_lastVoice;

  assign w_curInc    = i_phase_inc[16*int'(r_voiceIdx) +: 16];
  assign w_curEn     = i_voice_en[r_voiceIdx];
  assign w_lastVoice = (r_voiceIdx == VIDX_W'(NUM_VOICES - 1));
  assign o_busy      = (r_state != S_IDLE);

`ifdef GAIN_WEIGHT_EN
  logic [3:0] w_curGain;
  assign w_curGain = i_voice_gain[4*int'(r_voiceIdx) +: 4];
  assign w_term    = TERM_W'(i_lut_data) * TERM_W'(w_curGain);
`else
  // Gain input is kept on the port for pin compatibility but has no effect in this build.
  logic w_unused;
  assign w_unused = &{1'b0, i_voice_gain};
  assign w_term   = i_lut_data;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_voiceIdx  <= '0;
      r_acc       <= '0;
      o_lut_addr  <= '0;
      o_mix_out   <= '0;
      o_mix_valid <= 1'b0;
      o_overrun   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_phase[v] <= '0;
      end
    end else begin
      o_mix_valid <= 1'b0;
      // A tick is only honoured in IDLE; anything arriving mid-frame is dropped and remembered.
      if (i_sample_tick && (r_state != S_IDLE)) begin
        o_overrun <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (i_sample_tick) begin
            r_acc      <= '0;
            r_voiceIdx <= '0;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          o_lut_addr <= r_phase[r_voiceIdx][15:8];
          r_state    <= S_READ;
        end
        S_READ: begin
          if (w_curEn) begin
            r_acc <= r_acc + MIX_W'(w_term);
          end
          // Disabled voices park at phase 0 so they restart aligned when re-enabled.
          r_phase[r_voiceIdx] <= w_curEn ? (r_phase[r_voiceIdx] + w_curInc) : 16'h0000;
          if (w_lastVoice) begin
            r_state <= S_DONE;
          end else begin
            r_voiceIdx <= r_voiceIdx + VIDX_W'(1);
            r_state    <= S_ADDR;
          end
        end
        S_DONE: begin
          o_mix_out   <= r_acc;
          o_mix_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_scheduler.sv
// Directed self-checking bench for wavetable_scheduler with four voices and an async-read ROM model.
// Expected mix values for the gain test follow GAIN_WEIGHT_EN.
module tb_wavetable_scheduler;

`ifdef GAIN_WEIGHT_EN
  localparam int MIXW = 22;
`else
  localparam int MIXW = 18;
`endif

  logic            clk;
  logic            rstN;
  logic            sampleTick;
  logic [63:0]     phaseInc;
  logic [3:0]      voiceEn;
  logic [15:0]     voiceGain;
  logic [7:0]      lutAddr;
  logic [15:0]     lutData;
  logic [MIXW-1:0] mixOut;
  logic            mixValid;
  logic            busy;
  logic            overrun;

  int              romMode;
  logic [15:0]     romConst;

  int              compareCount;
  int              mismatchCount;

  int              validCycle;
  int              validCount;
  logic [31:0]     busyBits;
  logic [7:0]      addrSeen [4];
  logic [MIXW-1:0] mixAtValid;

  wavetable_scheduler #(.NUM_VOICES(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_sample_tick (sampleTick),
    .i_phase_inc   (phaseInc),
    .i_voice_en    (voiceEn),
    .i_voice_gain  (voiceGain),
    .o_lut_addr    (lutAddr),
    .i_lut_data    (lutData),
    .o_mix_out     (mixOut),
    .o_mix_valid   (mixValid),
    .o_busy        (busy),
    .o_overrun     (overrun)
  );

  // Mode 1 is a ramp table (data = address); otherwise every entry is romConst.
  assign lutData = (romMode == 1) ? {8'h00, lutAddr} : romConst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    rstN       = 1'b0;
    sampleTick = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  // Pulses a tick (sampled at edge 0), then watches cycles 1..span; optional second tick at extraTick.
  task automatic applyStimulus(input int extraTick, input int span);
    validCycle = -1;
    validCount = 0;
    busyBits   = '0;
    @(negedge clk);
    sampleTick = 1'b1;
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      sampleTick = (k == extraTick);
      if (busy) busyBits[k] = 1'b1;
      if (k == 2 || k == 4 || k == 6 || k == 8) addrSeen[(k-2)/2] = lutAddr;
      if (mixValid) begin
        validCount++;
        if (validCycle < 0) begin
          validCycle = k;
          mixAtValid = mixOut;
        end
      end
    end
    sampleTick = 1'b0;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rstN       = 1'b0;
    sampleTick = 1'b0;
    phaseInc   = '0;
    voiceEn    = 4'hF;
    voiceGain  = 16'h1111;
    romMode    = 0;
    romConst   = 16'h8000;

    // Reset values and a constant-table frame.
    resetDut();
    checkOutput("rst_lut_addr", 32'(lutAddr), 32'h0);
    checkOutput("rst_mix_out", 32'(mixOut), 32'h0);
    checkOutput("rst_mix_valid", 32'(mixValid), 32'h0);
    checkOutput("rst_overrun", 32'(overrun), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);

    applyStimulus(0, 20);
    checkOutput("t1_valid_cycle", 32'(validCycle), 32'd10);
    checkOutput("t1_valid_count", 32'(validCount), 32'd1);
    checkOutput("t1_mix_out", 32'(mixAtValid), 32'h20000);
    checkOutput("t1_busy_cycles", busyBits, 32'h0000_03FE);
    for (int v = 0; v < 4; v++) checkOutput("t1_lut_addr", 32'(addrSeen[v]), 32'h0);

    // Voice 0 sweeps the ramp table one entry per frame and wraps after 256 frames.
    resetDut();
    romMode  = 1;
    phaseInc = 64'h0000_0000_0000_0100;
    for (int n = 1; n <= 257; n++) begin
      applyStimulus(0, 19);
      checkOutput("t2_v0_addr", 32'(addrSeen[0]), 32'((n - 1) & 8'hFF));
      checkOutput("t2_mix_out", 32'(mixAtValid), 32'((n - 1) & 8'hFF));
    end

    // Tick while busy is dropped and latches overrun for good.
    checkOutput("t3_overrun_before", 32'(overrun), 32'h0);
    applyStimulus(4, 20);
    checkOutput("t3_valid_count", 32'(validCount), 32'd1);
    checkOutput("t3_valid_cycle", 32'(validCycle), 32'd10);
    checkOutput("t3_overrun_set", 32'(overrun), 32'h1);
    applyStimulus(0, 20);
    checkOutput("t3_clean_valid", 32'(validCycle), 32'd10);
    checkOutput("t3_overrun_sticky", 32'(overrun), 32'h1);

    // Disabling voice 3 silences it and parks its phase at zero.
    resetDut();
    romMode  = 1;
    phaseInc = 64'h1000_0000_0000_0100;
    voiceEn  = 4'hF;
    applyStimulus(0, 20);
    applyStimulus(0, 20);
    checkOutput("t4_both_mix", 32'(mixAtValid), 32'h11);
    voiceEn = 4'b0001;
    applyStimulus(0, 20);
    checkOutput("t4_v3_addr_stale", 32'(addrSeen[3]), 32'h20);
    checkOutput("t4_mix_v0_only", 32'(mixAtValid), 32'h02);
    applyStimulus(0, 20);
    checkOutput("t4_v3_addr_parked", 32'(addrSeen[3]), 32'h00);
    checkOutput("t4_mix_v0_only2", 32'(mixAtValid), 32'h03);
    voiceEn = 4'hF;
    applyStimulus(0, 20);
    checkOutput("t4_v3_reenabled", 32'(addrSeen[3]), 32'h00);
    checkOutput("t4_mix_reenabled", 32'(mixAtValid), 32'h04);
    applyStimulus(0, 20);
    checkOutput("t4_v3_advancing", 32'(addrSeen[3]), 32'h10);
    checkOutput("t4_mix_both", 32'(mixAtValid), 32'h15);

    // Reset in the middle of a frame aborts it without a pulse.
    resetDut();
    romMode  = 0;
    romConst = 16'h8000;
    phaseInc = '0;
    applyStimulus(0, 20);
    checkOutput("t5_prior_mix", 32'(mixAtValid), 32'h20000);
    @(negedge clk);
    sampleTick = 1'b1;
    validCount = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      sampleTick = 1'b0;
      if (mixValid) validCount++;
      if (k == 5) rstN = 1'b0;
      if (k == 6) begin
        checkOutput("t5_busy_after_rst", 32'(busy), 32'h0);
        checkOutput("t5_mix_after_rst", 32'(mixOut), 32'h0);
        checkOutput("t5_valid_after_rst", 32'(mixValid), 32'h0);
        rstN = 1'b1;
      end
    end
    checkOutput("t5_no_abort_pulse", 32'(validCount), 32'd0);
    applyStimulus(0, 20);
    checkOutput("t5_next_latency", 32'(validCycle), 32'd10);
    checkOutput("t5_next_mix", 32'(mixAtValid), 32'h20000);

    // Per-voice gain weighting (ignored when the feature is compiled out).
    resetDut();
    romMode   = 0;
    romConst  = 16'h1000;
    voiceGain = {4'd1, 4'd2, 4'd3, 4'd6};
    applyStimulus(0, 20);
`ifdef GAIN_WEIGHT_EN
    checkOutput("t6_gain_mix", 32'(mixAtValid), 32'h00C000);
`else
    checkOutput("t6_gain_mix", 32'(mixAtValid), 32'h04000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
